// File: rtl/instr_pkg.sv
// instr_pkg: shared widths, NOP encoding and the {pc, instr} entry type
package instr_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam logic [WIDTH_DEF-1:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [WIDTH_DEF-1:0] instr;
  } entry_t;
endpackage

// File: rtl/instr_queue_mem.sv
// instr_queue_mem: DEPTH x DW register array, one write port, one async read port
module instr_queue_mem #(
  parameter int DEPTH = 4,
  parameter int DW = 64,
  parameter int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [DEPTH];
  // storage is intentionally unreset; validity is tracked by the queue's count
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/instr_queue.sv
// instr_queue: DEPTH-entry FIFO of {pc, instr} between fetch and decode with flush
module instr_queue
  import instr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_instr,
  input  logic [ADDR_W-1:0]          in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  logic [ADDR_W+WIDTH-1:0] head;
  assign in_ready = count_q != CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign count = count_q;
  assign {out_pc, out_instr} = out_valid ? head : '0;
  instr_queue_mem #(.DEPTH(DEPTH), .DW(ADDR_W + WIDTH)) u_mem (
    .clk  (clk),
    .we   (push & ~flush),
    .waddr(wr_ptr_q),
    .wdata({in_pc, in_instr}),
    .raddr(rd_ptr_q),
    .rdata(head)
  );
  // pointers wrap by natural overflow; flush overrides any push/pop this cycle
  always_comb begin
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // control state register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed self-checking bench for instr_queue
module tb_instr_queue;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [31:0] in_instr = '0, in_pc = '0, out_instr, out_pc;
  logic [2:0] count;
  int vecs = 0, errs = 0;

  instr_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count got %0d want 0", count); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vecs++; if (out_pc !== 32'h0) begin errs++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    vecs++; if (out_instr !== 32'h0) begin errs++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(4 * i); in_instr = 32'hA0 + 32'(i);
      step();
      vecs++; if (count !== 3'(i + 1)) begin errs++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
    end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
    in_pc = 32'd16; in_instr = 32'hA4;
    step();
    in_valid = 1'b0;
    vecs++; if (count !== 3'd4) begin errs++; $display("FAIL fill_overflow_count got %0d want 4", count); end
    vecs++; if (out_pc !== 32'h0) begin errs++; $display("FAIL fill_head_pc got %h want 0", out_pc); end
    vecs++; if (out_instr !== 32'hA0) begin errs++; $display("FAIL fill_head_instr got %h want a0", out_instr); end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL drain_valid[%0d] got %b want 1", i, out_valid); end
      vecs++; if (out_pc !== 32'(4 * i)) begin errs++; $display("FAIL drain_pc[%0d] got %h want %h", i, out_pc, 4 * i); end
      vecs++; if (out_instr !== 32'hA0 + 32'(i)) begin errs++; $display("FAIL drain_instr[%0d] got %h want %h", i, out_instr, 32'hA0 + i); end
      step();
    end
    out_ready = 1'b0;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL drain_empty_valid got %b want 0", out_valid); end
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL drain_empty_count got %0d want 0", count); end
  endtask

  task automatic test_stream();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_pc = 32'(4 * i); in_instr = 32'hB0 + 32'(i);
      step();
      vecs++; if (count !== 3'd1) begin errs++; $display("FAIL stream_count[%0d] got %0d want 1", i, count); end
      vecs++; if (out_pc !== 32'(4 * i)) begin errs++; $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc, 4 * i); end
      vecs++; if (out_instr !== 32'hB0 + 32'(i)) begin errs++; $display("FAIL stream_instr[%0d] got %h want %h", i, out_instr, 32'hB0 + i); end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL stream_end_count got %0d want 0", count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h10 + 32'(4 * i); in_instr = 32'hC0 + 32'(i);
      step();
    end
    vecs++; if (count !== 3'd3) begin errs++; $display("FAIL flush_pre_count got %0d want 3", count); end
    flush = 1'b1; in_pc = 32'h100; in_instr = 32'hDEAD;
    step();
    flush = 1'b0;
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL flush_count got %0d want 0", count); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    vecs++; if (out_pc !== 32'h0) begin errs++; $display("FAIL flush_out_pc got %h want 0", out_pc); end
    in_pc = 32'h200; in_instr = 32'hE0;
    step();
    in_valid = 1'b0;
    vecs++; if (count !== 3'd1) begin errs++; $display("FAIL flush_repush_count got %0d want 1", count); end
    vecs++; if (out_pc !== 32'h200) begin errs++; $display("FAIL flush_repush_pc got %h want 200", out_pc); end
    vecs++; if (out_instr !== 32'hE0) begin errs++; $display("FAIL flush_repush_instr got %h want e0", out_instr); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL flush_final_count got %0d want 0", count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'h300 + 32'(4 * i); in_instr = 32'hF0 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    vecs++; if (count !== 3'd2) begin errs++; $display("FAIL arst_pre_count got %0d want 2", count); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL arst_count got %0d want 0", count); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
    vecs++; if (out_pc !== 32'h0) begin errs++; $display("FAIL arst_out_pc got %h want 0", out_pc); end
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_pc = 32'h400; in_instr = 32'h55;
    step();
    in_valid = 1'b0;
    vecs++; if (count !== 3'd1) begin errs++; $display("FAIL arst_resume_count got %0d want 1", count); end
    vecs++; if (out_pc !== 32'h400) begin errs++; $display("FAIL arst_resume_pc got %h want 400", out_pc); end
    vecs++; if (out_instr !== 32'h55) begin errs++; $display("FAIL arst_resume_instr got %h want 55", out_instr); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
